servant_ram_banked: RTL and testbench
=====================================

Name: servant_ram_banked

Overview:
- Wishbone-classic data/instruction RAM for the SERV user design, built from `BANKS` instances of the 1024x32 SRAM macro wrapper (`IHP_SRAM_1024x32_wrapper`).
- Successor of the single-macro RAM. Generalised in bank count, with configurable read wait states, bus-error response for unmapped addresses, and per-bank macro enable (only the addressed bank is enabled).
- Sits between the servant core's Wishbone port and the macros.

Parameters:
- BANKS, 2, number of 1024x32 macros (1..8; need not be a power of 2).
- BANK_AW, 10, word-address width of one macro (fixed by the macro).
- BANK_SEL_W, $clog2(BANKS) (min 1), derived width of the bank-index field.
- aw, BANK_AW+BANK_SEL_W+2, derived byte-address width.
- READ_WAIT, 0, extra wait cycles inserted before read data capture (0..7).

Ports:
- i_wb_clk  in  1  clock.
- i_wb_rst_n  in  1  asynchronous active-low reset.
- i_wb_adr  in  aw-2 ([aw-1:2])  word address; upper BANK_SEL_W bits select the bank.
- i_wb_dat  in  32  write data.
- i_wb_sel  in  4  byte lanes.
- i_wb_we  in  1  write enable.
- i_wb_cyc  in  1  cycle/strobe.
- o_wb_rdt  out  32  read data, registered.
- o_wb_ack  out  1  normal termination, registered.
- o_wb_err  out  1  error termination (unmapped bank), registered.

Behaviour:
- Reset (i_wb_rst_n low, asynchronous): state=IDLE; o_wb_ack=0; o_wb_err=0; o_wb_rdt=0; all request registers 0; all macro MEN/REN/WEN=0. Release is synchronous to i_wb_clk.
- FSM states: IDLE, ACCESS, WAIT, RESP, TERM.
- IDLE: on an edge sampling i_wb_cyc=1, capture adr/dat/sel/we and compute bank index.
  - Bank index >= BANKS -> TERM with o_wb_err<=1 and o_wb_rdt<=0. No macro is enabled.
  - Otherwise -> ACCESS.
- ACCESS, one cycle: only the addressed bank sees MEN=1, REN=!we, WEN=we.
  - Byte mask: each sel bit expanded to 8 mask bits.
  - Address and data come from the captured registers; all other banks have MEN=0.
  - Next state: write -> TERM with o_wb_ack<=1; read -> WAIT if READ_WAIT>0, else RESP.
- WAIT: counter counts READ_WAIT cycles, then -> RESP. All macro enables are 0; the macro output holds.
- RESP: o_wb_rdt<=DOUT of the captured bank; o_wb_ack<=1; -> TERM.
- TERM: ack/err high for exactly this one cycle. Next edge clears them and returns to IDLE, regardless of i_wb_cyc.
- Latency, counted from edge E0 that samples cyc in IDLE:
  - Write: ack high in cycle after E1.
  - Read: ack high in cycle after E2+READ_WAIT.
  - Error: err high in cycle after E0.
- Back-to-back: at least one IDLE cycle separates transactions. If cyc is still high on the TERM->IDLE edge, it is not re-sampled until the following edge.
- Abort: if i_wb_cyc drops during ACCESS, WAIT or RESP:
  - A macro operation already issued in ACCESS completes; a write commits.
  - No ack/err is asserted; the FSM returns to IDLE on the next edge.
  - o_wb_rdt keeps its previous value.
- ack and err are never high simultaneously.
- o_wb_rdt changes only in RESP or on an error; it is stable otherwise.
- Reset mid-transaction aborts immediately. Macro contents are undefined only if reset falls during ACCESS of a write.

Decomposition:
- Shared package `servant_ram_pkg`: FSM state encoding (IDLE..TERM), the macro depth constant 1024, and the byte-mask expansion function.
- Sub-module `servant_ram_bank`: one macro wrapper plus enable gating and mask expansion, instantiated BANKS times in a generate loop.
- Read mux and FSM stay in the top module.

Test Plan:
- BANKS=2, READ_WAIT=0: write 0xDEADBEEF sel=4'hF to word 0x005 -> ack 1 cycle after E1. Read word 0x005 -> ack after E2, rdt=0xDEADBEEF. Bank 1 MEN stays 0 throughout.
- Byte lanes: preload 0x11223344 at word 0x400 (bank 1), write 0xAABBCCDD with sel=4'b0101 -> read returns 0x11BB33DD.
- READ_WAIT=3: read -> ack exactly 3 cycles later than the READ_WAIT=0 case; o_wb_rdt stable throughout TERM.
- BANKS=3: access word 0xC00 (bank index 3) -> o_wb_err=1 for one cycle after E0, ack=0, rdt=0, no macro enabled. A later valid access completes normally.
- Abort: drop cyc in ACCESS of a write to 0x010 -> no ack, FSM in IDLE next cycle; subsequent read of 0x010 returns the new data.
- Async reset asserted in WAIT -> o_wb_ack/err/rdt=0 and state IDLE without a clock edge. After release, a read completes with the normal latency.

Source files
------------

// File: rtl/servant_ram_pkg.sv
// Shared definitions for the banked SERV RAM: FSM encoding, macro geometry
// and the byte-lane to bit-mask expansion used by every bank.
package servant_ram_pkg;

  localparam int unsigned MACRO_DEPTH = 1024;
  localparam int unsigned MACRO_AW    = $clog2(MACRO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    WAIT,
    RESP,
    TERM
  } state_e;

  function automatic logic [31:0] expand_sel(input logic [3:0] sel);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[i*8 +: 8] = {8{sel[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/IHP_SRAM_1024x32_wrapper.sv
// Behavioural stand-in for the 1024x32 SRAM macro wrapper: synchronous
// bit-masked write, synchronous read, output holds when not reading.
module IHP_SRAM_1024x32_wrapper (
  input  logic        A_CLK,
  input  logic        A_MEN,
  input  logic        A_WEN,
  input  logic        A_REN,
  input  logic [9:0]  A_ADDR,
  input  logic [31:0] A_DIN,
  input  logic [31:0] A_BM,
  output logic [31:0] A_DOUT
);

  logic [31:0] mem_q [1024];
  logic [31:0] dout_q;

  always_ff @(posedge A_CLK) begin
    if (A_MEN && A_WEN) begin
      mem_q[A_ADDR] <= (mem_q[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
    end
    if (A_MEN && A_REN) begin
      dout_q <= mem_q[A_ADDR];
    end
  end

  assign A_DOUT = dout_q;

endmodule

// File: rtl/servant_ram_bank.sv
// One RAM bank: a single macro with enable gating and byte-mask expansion.
module servant_ram_bank
  import servant_ram_pkg::*;
(
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [MACRO_AW-1:0] adr,
  input  logic [31:0]         dat,
  input  logic [3:0]          sel,
  output logic [31:0]         dout
);

  logic        men;
  logic        ren;
  logic        wen;
  logic [31:0] bm;

  always_comb begin
    men = en;
    ren = en & ~we;
    wen = en & we;
    bm  = expand_sel(sel);
  end

  IHP_SRAM_1024x32_wrapper u_macro (
    .A_CLK  (clk),
    .A_MEN  (men),
    .A_WEN  (wen),
    .A_REN  (ren),
    .A_ADDR (adr),
    .A_DIN  (dat),
    .A_BM   (bm),
    .A_DOUT (dout)
  );

endmodule

// File: rtl/servant_ram_banked.sv
// Wishbone-classic RAM for SERV built from BANKS macros, with optional read
// wait states and an error response for addresses beyond the last bank.
module servant_ram_banked
  import servant_ram_pkg::*;
#(
  parameter int BANKS      = 2,
  parameter int BANK_AW    = 10,
  parameter int BANK_SEL_W = (BANKS > 1) ? $clog2(BANKS) : 1,
  parameter int aw         = BANK_AW + BANK_SEL_W + 2,
  parameter int READ_WAIT  = 0
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic [aw-1:2] i_wb_adr,
  input  logic [31:0]   i_wb_dat,
  input  logic [3:0]    i_wb_sel,
  input  logic          i_wb_we,
  input  logic          i_wb_cyc,
  output logic [31:0]   o_wb_rdt,
  output logic          o_wb_ack,
  output logic          o_wb_err
);

  localparam int CNT_W = 3;

  state_e                state_q, state_d;
  logic [BANK_AW-1:0]    off_q, off_d;
  logic [BANK_SEL_W-1:0] bank_q, bank_d;
  logic [31:0]           dat_q, dat_d;
  logic [3:0]            sel_q, sel_d;
  logic                  we_q, we_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [31:0]           rdt_q, rdt_d;

  logic [BANK_SEL_W-1:0] req_bank;
  logic                  req_bad;
  logic [BANKS-1:0]      bank_en;
  logic [31:0]           bank_dout [BANKS];
  logic [31:0]           rd_data;

  always_comb begin
    req_bank = i_wb_adr[aw-1 -: BANK_SEL_W];
    req_bad  = {{(32-BANK_SEL_W){1'b0}}, req_bank} >= 32'(BANKS);
  end

  // Only the captured bank is enabled, and only for the single ACCESS cycle.
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < BANKS; b++) begin
      bank_en[b] = (state_q == ACCESS) && (bank_q == BANK_SEL_W'(b));
      if (bank_q == BANK_SEL_W'(b)) begin
        rd_data = bank_dout[b];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    bank_d  = bank_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdt_d   = rdt_q;
    case (state_q)
      IDLE: begin
        if (i_wb_cyc) begin
          off_d  = i_wb_adr[BANK_AW+1:2];
          bank_d = req_bank;
          dat_d  = i_wb_dat;
          sel_d  = i_wb_sel;
          we_d   = i_wb_we;
          if (req_bad) begin
            state_d = TERM;
            err_d   = 1'b1;
            rdt_d   = '0;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        // The macro operation is issued on this edge even if cyc has dropped.
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (we_q) begin
          state_d = TERM;
          ack_d   = 1'b1;
        end else if (READ_WAIT > 0) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(READ_WAIT - 1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (!i_wb_cyc) begin
          state_d = IDLE;
        end else begin
          rdt_d   = rd_data;
          ack_d   = 1'b1;
          state_d = TERM;
        end
      end
      TERM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= IDLE;
      off_q   <= '0;
      bank_q  <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      bank_q  <= bank_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdt_q   <= rdt_d;
    end
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    servant_ram_bank u_bank (
      .clk  (i_wb_clk),
      .en   (bank_en[b]),
      .we   (we_q),
      .adr  (off_q),
      .dat  (dat_q),
      .sel  (sel_q),
      .dout (bank_dout[b])
    );
  end

  assign o_wb_rdt = rdt_q;
  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;

endmodule

// File: tb/tb_servant_ram_banked.sv
// Scoreboard bench for servant_ram_banked: two instances (2 banks/no wait,
// 3 banks/3 wait states) driven with directed and random Wishbone traffic.
module tb_servant_ram_banked;
  import servant_ram_pkg::*;

  typedef struct {
    bit          is_err;
    logic [31:0] rdt;
    int          at;
  } exp_t;

  logic        clk = 1'b0;
  int          cycle = 0;
  int          checks = 0;
  int          failures = 0;

  logic        rst_n [2];
  logic        cyc [2];
  logic        we [2];
  logic [31:0] dat [2];
  logic [3:0]  sel [2];
  logic [10:0] adr_a;
  logic [11:0] adr_b;
  wire  [31:0] rdt [2];
  wire         ack [2];
  wire         err [2];

  exp_t        sbq0 [$];
  exp_t        sbq1 [$];
  logic [31:0] mem [int];
  logic [31:0] last_rdt [2];
  logic [31:0] mon_rdt [2];

  wire  [7:0]  en_a = {6'b0, dut_a.bank_en};
  wire  [7:0]  en_b = {5'b0, dut_b.bank_en};
  state_e      st_a;
  state_e      st_b;
  assign st_a = dut_a.state_q;
  assign st_b = dut_b.state_q;

  servant_ram_banked #(.BANKS(2), .READ_WAIT(0)) dut_a (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n[0]),
    .i_wb_adr   (adr_a),
    .i_wb_dat   (dat[0]),
    .i_wb_sel   (sel[0]),
    .i_wb_we    (we[0]),
    .i_wb_cyc   (cyc[0]),
    .o_wb_rdt   (rdt[0]),
    .o_wb_ack   (ack[0]),
    .o_wb_err   (err[0])
  );

  servant_ram_banked #(.BANKS(3), .READ_WAIT(3)) dut_b (
    .i_wb_clk   (clk),
    .i_wb_rst_n (rst_n[1]),
    .i_wb_adr   (adr_b),
    .i_wb_dat   (dat[1]),
    .i_wb_sel   (sel[1]),
    .i_wb_we    (we[1]),
    .i_wb_cyc   (cyc[1]),
    .o_wb_rdt   (rdt[1]),
    .o_wb_ack   (ack[1]),
    .o_wb_err   (err[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic int nb(input int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int rw(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [7:0] en_of(input int d);
    return (d == 0) ? en_a : en_b;
  endfunction

  function automatic state_e st_of(input int d);
    return (d == 0) ? st_a : st_b;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s dut=%0d got=0x%08h expected=0x%08h (t=%0t)", name, d, act, expv, $time);
    end
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   depth;
    if (ack[d] || err[d]) begin
      check("ack_err_excl", d, {31'b0, ack[d] & err[d]}, 32'd0);
      depth = (d == 0) ? sbq0.size() : sbq1.size();
      if (depth == 0) begin
        check("unexpected_resp", d, {30'b0, ack[d], err[d]}, 32'd0);
      end else begin
        if (d == 0) e = sbq0.pop_front();
        else        e = sbq1.pop_front();
        check("resp_kind", d, {30'b0, ack[d], err[d]}, e.is_err ? 32'd1 : 32'd2);
        check("resp_cycle", d, cycle, e.at);
        check("resp_rdt", d, rdt[d], e.rdt);
        mon_rdt[d] = e.rdt;
      end
    end else begin
      check("rdt_stable", d, rdt[d], mon_rdt[d]);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      mon(0);
      mon(1);
    end
  end

  // abort_at: 0 = complete normally; k = cyc is low on the k-th edge after E0
  task automatic txn(input int d, input bit w, input logic [11:0] a, input logic [31:0] wd,
                     input logic [3:0] s, input int abort_at);
    exp_t        e;
    int          key;
    int          bank;
    int          start;
    bit          bad;
    bit          got;
    logic [31:0] old_w;
    key  = d * 65536 + int'(a);
    bank = int'(a) / 1024;
    bad  = (bank >= nb(d));
    @(posedge clk);
    #1;
    cyc[d] = 1'b1;
    we[d]  = w;
    dat[d] = wd;
    sel[d] = s;
    if (d == 0) adr_a = a[10:0];
    else        adr_b = a;
    start = cycle + 1;
    e = '{1'b0, 32'd0, 0};
    if (bad) begin
      e = '{1'b1, 32'd0, start};
      last_rdt[d] = 32'd0;
    end else if (w) begin
      old_w = mem.exists(key) ? mem[key] : 32'd0;
      mem[key] = merge(old_w, wd, s);
      e = '{1'b0, last_rdt[d], start + 1};
    end else if (abort_at == 0) begin
      last_rdt[d] = mem[key];
      e = '{1'b0, mem[key], start + 2 + rw(d)};
    end
    if (abort_at == 0) begin
      if (d == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check("bank_en", d, {24'b0, en_of(d)}, bad ? 32'd0 : (32'd1 << bank));
    if (abort_at > 0) begin
      for (int i = 1; i < abort_at; i++) begin
        @(posedge clk);
        #1;
      end
      cyc[d] = 1'b0;
      @(posedge clk);
      #1;
      check("abort_idle", d, 32'(st_of(d)), 32'(IDLE));
    end else begin
      got = 1'b0;
      for (int i = 0; i < 16 && !got; i++) begin
        if (ack[d] || err[d]) got = 1'b1;
        else @(negedge clk);
      end
      check("resp_seen", d, {31'b0, got}, 32'd1);
      @(posedge clk);
      #1;
      cyc[d] = 1'b0;
    end
  endtask

  task automatic reset_in_wait(input int d, input logic [11:0] a);
    @(posedge clk);
    #1;
    cyc[d] = 1'b1;
    we[d]  = 1'b0;
    sel[d] = 4'hF;
    if (d == 0) adr_a = a[10:0];
    else        adr_b = a;
    @(posedge clk);
    @(posedge clk);
    #3;
    check("pre_reset_state", d, 32'(st_of(d)), 32'(WAIT));
    rst_n[d]    = 1'b0;
    mon_rdt[d]  = 32'd0;
    last_rdt[d] = 32'd0;
    #1;
    check("rst_ack", d, {31'b0, ack[d]}, 32'd0);
    check("rst_err", d, {31'b0, err[d]}, 32'd0);
    check("rst_rdt", d, rdt[d], 32'd0);
    check("rst_state", d, 32'(st_of(d)), 32'(IDLE));
    cyc[d] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[d] = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d]    = 1'b1;
      cyc[d]      = 1'b0;
      we[d]       = 1'b0;
      dat[d]      = 32'd0;
      sel[d]      = 4'd0;
      last_rdt[d] = 32'd0;
      mon_rdt[d]  = 32'd0;
    end
    adr_a = '0;
    adr_b = '0;
    #1;
    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check("reset_ack", d, {31'b0, ack[d]}, 32'd0);
      check("reset_err", d, {31'b0, err[d]}, 32'd0);
      check("reset_rdt", d, rdt[d], 32'd0);
      check("reset_state", d, 32'(st_of(d)), 32'(IDLE));
    end
    @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // Two banks, no wait states
    txn(0, 1'b1, 12'h005, 32'hDEADBEEF, 4'hF, 0);
    txn(0, 1'b0, 12'h005, 32'd0, 4'hF, 0);
    txn(0, 1'b1, 12'h400, 32'h11223344, 4'hF, 0);
    txn(0, 1'b1, 12'h400, 32'hAABBCCDD, 4'b0101, 0);
    txn(0, 1'b0, 12'h400, 32'd0, 4'hF, 0);
    txn(0, 1'b1, 12'h010, 32'hCAFEF00D, 4'hF, 1);
    txn(0, 1'b0, 12'h010, 32'd0, 4'hF, 0);
    txn(0, 1'b0, 12'h005, 32'd0, 4'hF, 2);
    txn(0, 1'b1, 12'h006, 32'h01234567, 4'hF, 0);

    // Three banks, three wait states, unmapped fourth bank
    txn(1, 1'b1, 12'h805, 32'h55AA00FF, 4'hF, 0);
    txn(1, 1'b0, 12'h805, 32'd0, 4'hF, 0);
    txn(1, 1'b0, 12'hC00, 32'd0, 4'hF, 0);
    txn(1, 1'b1, 12'hC00, 32'h12345678, 4'hF, 0);
    txn(1, 1'b0, 12'h805, 32'd0, 4'hF, 0);
    txn(1, 1'b0, 12'h805, 32'd0, 4'hF, 2);
    txn(1, 1'b0, 12'h805, 32'd0, 4'hF, 5);
    txn(1, 1'b1, 12'h003, 32'h0BADF00D, 4'hF, 0);
    txn(1, 1'b0, 12'h003, 32'd0, 4'hF, 0);
    reset_in_wait(1, 12'h805);
    txn(1, 1'b0, 12'h003, 32'd0, 4'hF, 0);

    // Random traffic over a small address pool per bank
    for (int d = 0; d < 2; d++) begin
      for (int b = 0; b < nb(d); b++) begin
        for (int p = 0; p < 4; p++) begin
          txn(d, 1'b1, 12'(b * 1024 + p * 37 + 1), $urandom, 4'hF, 0);
        end
      end
    end
    for (int n = 0; n < 60; n++) begin
      int   d;
      int   b;
      int   ab;
      bit   w;
      d  = int'($urandom_range(0, 1));
      b  = int'($urandom_range(0, (d == 0) ? 1 : 3));
      w  = 1'($urandom_range(0, 1));
      ab = 0;
      if (b < nb(d) && $urandom_range(0, 5) == 0) begin
        ab = w ? 1 : int'($urandom_range(1, 2 + rw(d)));
      end
      txn(d, w, 12'(b * 1024 + int'($urandom_range(0, 3)) * 37 + 1), $urandom,
          4'($urandom_range(1, 15)), ab);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 0, sbq0.size() + sbq1.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
